// File: rtl/bullet_scheduler_pkg.sv
// Shared encodings and screen limits for the bullet scheduler and its slots.
package bullet_scheduler_pkg;

  localparam logic [1:0] ICON_UP    = 2'b00;
  localparam logic [1:0] ICON_DOWN  = 2'b01;
  localparam logic [1:0] ICON_LEFT  = 2'b10;
  localparam logic [1:0] ICON_RIGHT = 2'b11;

  localparam int X_MAX  = 639;
  localparam int Y_MAX  = 479;
  localparam int MUZZLE = 15;
  localparam int OWN_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_EXPL = 2'd2
  } slot_state_t;

endpackage

// File: rtl/bullet_scheduler_slot.sv
// One bullet slot: launch on load, fly one pixel per step, explode, then free.
// state  | meaning
// S_IDLE | free, all fields cleared
// S_FLY  | bullet moving, counts as the owner's live bullet
// S_EXPL | explosion shown at frozen position until the counter expires
module bullet_slot
  import bullet_scheduler_pkg::*;
#(
  parameter int EXPL_STEPS = 32
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  input  logic [9:0]       load_x,
  input  logic [8:0]       load_y,
  input  logic [1:0]       load_dir,
  input  logic [OWN_W-1:0] load_owner,
  input  logic             hit,
  output logic             act,
  output logic             expl,
  output logic [9:0]       x,
  output logic [8:0]       y,
  output logic [1:0]       dir,
  output logic [OWN_W-1:0] owner
);

  localparam int EC_W = $clog2(EXPL_STEPS + 1);

  slot_state_t     state;
  logic [EC_W-1:0] ecnt;
  logic            at_edge;

  // The next move would take the bullet off screen: explode instead of wrapping.
  always_comb begin
    case (dir)
      ICON_UP:   at_edge = (y == 9'd0);
      ICON_DOWN: at_edge = (y == 9'(Y_MAX));
      ICON_LEFT: at_edge = (x == 10'd0);
      default:   at_edge = (x == 10'(X_MAX));
    endcase
  end

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      state <= S_IDLE;
      act   <= 1'b0;
      expl  <= 1'b0;
      x     <= '0;
      y     <= '0;
      dir   <= '0;
      owner <= '0;
      ecnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            state <= S_FLY;
            act   <= 1'b1;
            x     <= load_x;
            y     <= load_y;
            dir   <= load_dir;
            owner <= load_owner;
          end
        end
        S_FLY: begin
          if (hit || (step && at_edge)) begin
            state <= S_EXPL;
            act   <= 1'b0;
            expl  <= 1'b1;
            ecnt  <= EC_W'(EXPL_STEPS);
          end else if (step) begin
            case (dir)
              ICON_UP:   y <= y - 9'd1;
              ICON_DOWN: y <= y + 9'd1;
              ICON_LEFT: x <= x - 10'd1;
              default:   x <= x + 10'd1;
            endcase
          end
        end
        S_EXPL: begin
          if (step) begin
            if (ecnt <= EC_W'(1)) begin
              state <= S_IDLE;
              expl  <= 1'b0;
              x     <= '0;
              y     <= '0;
              dir   <= '0;
              owner <= '0;
              ecnt  <= '0;
            end else begin
              ecnt <= ecnt - EC_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Shared bullet pool: round-robin fire arbitration, per-tank cooldown, step timer.
module bullet_scheduler
  import bullet_scheduler_pkg::*;
#(
  parameter int N_TANK         = 4,
  parameter int N_SLOT         = 4,
  parameter int STEP_CNT       = 100000,
  parameter int COOLDOWN_STEPS = 64,
  parameter int EXPL_STEPS     = 32
) (
  input  logic                      clk25,
  input  logic                      reset_n,
  input  logic [N_TANK-1:0]         fire_req,
  input  logic [10*N_TANK-1:0]      tank_x,
  input  logic [9*N_TANK-1:0]       tank_y,
  input  logic [2*N_TANK-1:0]       tank_dir,
  input  logic [N_SLOT-1:0]         hit_slot,
  output logic [N_TANK-1:0]         fire_gnt,
  output logic [N_SLOT-1:0]         slot_act,
  output logic [N_SLOT-1:0]         slot_expl,
  output logic [10*N_SLOT-1:0]      slot_x,
  output logic [9*N_SLOT-1:0]       slot_y,
  output logic [2*N_SLOT-1:0]       slot_dir,
  output logic [OWN_W*N_SLOT-1:0]   slot_owner
);

  localparam int SC_W = $clog2(STEP_CNT);
  localparam int CD_W = $clog2(COOLDOWN_STEPS + 1);

  logic [SC_W-1:0]  step_cnt;
  logic             step;
  logic [CD_W-1:0]  cooldown [N_TANK];
  logic [OWN_W-1:0] rr_ptr;
  logic [N_TANK-1:0] live, elig;
  logic [N_SLOT-1:0] first_idle, slot_load;
  logic              found, grant;
  logic [OWN_W-1:0]  winner;
  logic [9:0]        sel_x;
  logic [8:0]        sel_y;
  logic [1:0]        sel_dir;

  assign step = (step_cnt == SC_W'(STEP_CNT - 1));

  always_comb begin
    live = '0;
    elig = '0;
    for (int t = 0; t < N_TANK; t++) begin
      for (int s = 0; s < N_SLOT; s++)
        if (slot_act[s] && slot_owner[OWN_W*s +: OWN_W] == OWN_W'(t)) live[t] = 1'b1;
      elig[t] = fire_req[t] && !live[t] && (cooldown[t] == '0);
    end
  end

  // Scan from rr_ptr upward; the first eligible tank wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_TANK; k++)
      for (int t = 0; t < N_TANK; t++)
        if (!found && elig[t] && t == (int'(rr_ptr) + k) % N_TANK) begin
          found  = 1'b1;
          winner = OWN_W'(t);
        end
  end

  always_comb begin
    first_idle = '0;
    for (int s = N_SLOT - 1; s >= 0; s--)
      if (!slot_act[s] && !slot_expl[s]) first_idle = N_SLOT'(1) << s;
    grant     = found && (first_idle != '0);
    slot_load = grant ? first_idle : '0;
  end

  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_dir = '0;
    for (int t = 0; t < N_TANK; t++)
      if (winner == OWN_W'(t)) begin
        sel_x   = tank_x[10*t +: 10] + 10'(MUZZLE);
        sel_y   = tank_y[9*t +: 9] + 9'(MUZZLE);
        sel_dir = tank_dir[2*t +: 2];
      end
  end

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      step_cnt <= '0;
      rr_ptr   <= '0;
      fire_gnt <= '0;
      for (int t = 0; t < N_TANK; t++) cooldown[t] <= '0;
    end else begin
      step_cnt <= step ? '0 : step_cnt + SC_W'(1);
      for (int t = 0; t < N_TANK; t++) begin
        if (grant && winner == OWN_W'(t)) begin
          fire_gnt[t] <= 1'b1;
          cooldown[t] <= CD_W'(COOLDOWN_STEPS);
        end else begin
          fire_gnt[t] <= 1'b0;
          if (step && cooldown[t] != '0) cooldown[t] <= cooldown[t] - CD_W'(1);
        end
      end
      if (grant) rr_ptr <= OWN_W'((int'(winner) + 1) % N_TANK);
    end
  end

  for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
    bullet_slot #(.EXPL_STEPS(EXPL_STEPS)) u_slot (
      .clk25      (clk25),
      .reset_n    (reset_n),
      .step       (step),
      .load       (slot_load[i]),
      .load_x     (sel_x),
      .load_y     (sel_y),
      .load_dir   (sel_dir),
      .load_owner (winner),
      .hit        (hit_slot[i]),
      .act        (slot_act[i]),
      .expl       (slot_expl[i]),
      .x          (slot_x[10*i +: 10]),
      .y          (slot_y[9*i +: 9]),
      .dir        (slot_dir[2*i +: 2]),
      .owner      (slot_owner[OWN_W*i +: OWN_W])
    );
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed scenarios plus randomized traffic against a behavioural pool model.
module tb_bullet_scheduler;
  localparam int N_TANK = 4, N_SLOT = 4, STEP_CNT = 4, COOLDOWN_STEPS = 8, EXPL_STEPS = 2;
  localparam int OWN_W = 2;

  logic clk25 = 1'b0;
  logic reset_n = 1'b0;
  logic [N_TANK-1:0] fire_req = '0;
  logic [10*N_TANK-1:0] tank_x = '0;
  logic [9*N_TANK-1:0] tank_y = '0;
  logic [2*N_TANK-1:0] tank_dir = '0;
  logic [N_SLOT-1:0] hit_slot = '0;
  logic [N_TANK-1:0] fire_gnt;
  logic [N_SLOT-1:0] slot_act, slot_expl;
  logic [10*N_SLOT-1:0] slot_x;
  logic [9*N_SLOT-1:0] slot_y;
  logic [2*N_SLOT-1:0] slot_dir;
  logic [OWN_W*N_SLOT-1:0] slot_owner;

  int n_pass = 0;
  int n_total = 0;

  bullet_scheduler #(
    .N_TANK(N_TANK), .N_SLOT(N_SLOT), .STEP_CNT(STEP_CNT),
    .COOLDOWN_STEPS(COOLDOWN_STEPS), .EXPL_STEPS(EXPL_STEPS)
  ) dut (
    .clk25(clk25), .reset_n(reset_n), .fire_req(fire_req), .tank_x(tank_x),
    .tank_y(tank_y), .tank_dir(tank_dir), .hit_slot(hit_slot), .fire_gnt(fire_gnt),
    .slot_act(slot_act), .slot_expl(slot_expl), .slot_x(slot_x), .slot_y(slot_y),
    .slot_dir(slot_dir), .slot_owner(slot_owner)
  );

  always #5 clk25 = ~clk25;

  // Reference model: 0 free, 1 flying, 2 exploding.
  int m_st[N_SLOT], m_x[N_SLOT], m_y[N_SLOT], m_dir[N_SLOT], m_own[N_SLOT], m_ec[N_SLOT];
  int m_cd[N_TANK];
  int m_rr = 0, m_cnt = 0, m_steps = 0, m_gnt_t = -1;
  bit m_step_now = 0;

  always @(posedge clk25) begin : model
    int win, fre, nx, ny;
    bit stp, is_live;
    if (!reset_n) begin
      for (int s = 0; s < N_SLOT; s++) begin
        m_st[s] = 0; m_x[s] = 0; m_y[s] = 0; m_dir[s] = 0; m_own[s] = 0; m_ec[s] = 0;
      end
      for (int t = 0; t < N_TANK; t++) m_cd[t] = 0;
      m_rr = 0; m_cnt = 0; m_gnt_t = -1; m_step_now = 0;
    end else begin
      stp = (m_cnt == STEP_CNT - 1);
      m_cnt = stp ? 0 : m_cnt + 1;
      m_step_now = stp;
      if (stp) m_steps++;
      win = -1;
      for (int k = 0; k < N_TANK; k++) begin
        int t;
        t = (m_rr + k) % N_TANK;
        is_live = 0;
        for (int s = 0; s < N_SLOT; s++) if (m_st[s] == 1 && m_own[s] == t) is_live = 1;
        if (win < 0 && fire_req[t] && m_cd[t] == 0 && !is_live) win = t;
      end
      fre = -1;
      for (int s = 0; s < N_SLOT; s++) if (fre < 0 && m_st[s] == 0) fre = s;
      for (int s = 0; s < N_SLOT; s++) begin
        if (m_st[s] == 1) begin
          if (hit_slot[s]) begin
            m_st[s] = 2; m_ec[s] = EXPL_STEPS;
          end else if (stp) begin
            nx = m_x[s] + (m_dir[s] == 3 ? 1 : m_dir[s] == 2 ? -1 : 0);
            ny = m_y[s] + (m_dir[s] == 1 ? 1 : m_dir[s] == 0 ? -1 : 0);
            if (nx < 0 || nx > 639 || ny < 0 || ny > 479) begin
              m_st[s] = 2; m_ec[s] = EXPL_STEPS;
            end else begin
              m_x[s] = nx; m_y[s] = ny;
            end
          end
        end else if (m_st[s] == 2 && stp) begin
          m_ec[s]--;
          if (m_ec[s] == 0) begin
            m_st[s] = 0; m_x[s] = 0; m_y[s] = 0; m_dir[s] = 0; m_own[s] = 0;
          end
        end
      end
      for (int t = 0; t < N_TANK; t++) if (stp && m_cd[t] > 0) m_cd[t]--;
      m_gnt_t = -1;
      if (win >= 0 && fre >= 0) begin
        m_gnt_t = win;
        m_st[fre] = 1;
        m_x[fre] = (int'(tank_x[10*win +: 10]) + 15) % 1024;
        m_y[fre] = (int'(tank_y[9*win +: 9]) + 15) % 512;
        m_dir[fre] = int'(tank_dir[2*win +: 2]);
        m_own[fre] = win;
        m_cd[win] = COOLDOWN_STEPS;
        m_rr = (win + 1) % N_TANK;
      end
    end
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; fire_req = '0; hit_slot = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic set_tank(input int t, input int x, input int y, input int d);
    tank_x[10*t +: 10] = 10'(x);
    tank_y[9*t +: 9] = 9'(y);
    tank_dir[2*t +: 2] = 2'(d);
  endtask

  task automatic wait_steps(input int n, output bit ok);
    int st;
    st = m_steps;
    ok = 0;
    for (int i = 0; i < n * STEP_CNT + 8; i++) begin
      tick();
      if (m_steps - st >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({fire_gnt, slot_act, slot_expl} !== '0) $display("FAIL reset_flags got %h want 0", {fire_gnt, slot_act, slot_expl});
    else n_pass++;
    n_total++;
    if ({slot_x, slot_y, slot_dir, slot_owner} !== '0) $display("FAIL reset_fields got %h want 0", {slot_x, slot_y, slot_dir, slot_owner});
    else n_pass++;
  endtask

  task automatic test_single_fire();
    bit ok;
    do_reset();
    set_tank(0, 100, 200, 3);
    fire_req = 4'b0001;
    tick();
    fire_req = '0;
    n_total++;
    if (fire_gnt !== 4'b0001 || slot_act !== 4'b0001) $display("FAIL single_grant got %b/%b want 0001/0001", fire_gnt, slot_act);
    else n_pass++;
    n_total++;
    if (slot_x[9:0] !== 10'd115 || slot_y[8:0] !== 9'd215 || slot_owner[1:0] !== 2'd0)
      $display("FAIL single_launch got x=%0d y=%0d own=%0d want 115 215 0", slot_x[9:0], slot_y[8:0], slot_owner[1:0]);
    else n_pass++;
    tick();
    n_total++;
    if (fire_gnt !== 4'b0000) $display("FAIL single_pulse got %b want 0000", fire_gnt);
    else n_pass++;
    wait_steps(3, ok);
    n_total++;
    if (!ok || slot_x[9:0] !== 10'd118 || slot_y[8:0] !== 9'd215)
      $display("FAIL single_move got x=%0d y=%0d ok=%0d want 118 215 1", slot_x[9:0], slot_y[8:0], ok);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok, got, prev_idle;
    int s0;
    do_reset();
    set_tank(0, 100, 100, 3); set_tank(1, 200, 150, 2);
    set_tank(2, 300, 200, 1); set_tank(3, 400, 250, 0);
    fire_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (fire_gnt !== 4'(1 << i) || !slot_act[i] || slot_owner[2*i +: 2] !== 2'(i))
        $display("FAIL simul_grant%0d got gnt=%b own=%0d want %b %0d", i, fire_gnt, slot_owner[2*i +: 2], 4'(1 << i), i);
      else n_pass++;
    end
    fire_req = '0;
    wait_steps(8, ok);
    hit_slot = 4'b0001;
    tick();
    hit_slot = '0;
    fire_req = 4'b0001;
    s0 = m_steps;
    got = 0;
    prev_idle = 0;
    for (int i = 0; i < 40; i++) begin
      prev_idle = !slot_act[0] && !slot_expl[0];
      tick();
      if (fire_gnt != '0) begin got = 1; break; end
    end
    fire_req = '0;
    n_total++;
    if (!ok || !got || fire_gnt !== 4'b0001 || m_steps - s0 != 2 || !prev_idle)
      $display("FAIL pool_full got gnt=%b steps=%0d idle_before=%0d want 0001 2 1", fire_gnt, m_steps - s0, prev_idle);
    else n_pass++;
    n_total++;
    if (!slot_act[0] || slot_owner[1:0] !== 2'd0) $display("FAIL pool_reuse got act=%b own=%0d want 1 0", slot_act[0], slot_owner[1:0]);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int s_grant;
    bit hit_done, got;
    do_reset();
    set_tank(2, 300, 200, 3); set_tank(3, 400, 300, 2);
    fire_req = 4'b0100;
    tick();
    fire_req = 4'b1100;
    s_grant = m_steps;
    n_total++;
    if (fire_gnt !== 4'b0100 || slot_owner[1:0] !== 2'd2) $display("FAIL rr_first got %b own=%0d want 0100 2", fire_gnt, slot_owner[1:0]);
    else n_pass++;
    tick();
    fire_req = 4'b0100;
    n_total++;
    if (fire_gnt !== 4'b1000 || slot_owner[3:2] !== 2'd3) $display("FAIL rr_second got %b own=%0d want 1000 3", fire_gnt, slot_owner[3:2]);
    else n_pass++;
    hit_done = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (!hit_done && m_steps - s_grant >= 2) begin hit_slot = 4'b0001; hit_done = 1; end
      tick();
      hit_slot = '0;
      if (fire_gnt != '0) begin got = 1; break; end
    end
    fire_req = '0;
    n_total++;
    if (!got || fire_gnt !== 4'b0100 || m_steps - s_grant != COOLDOWN_STEPS)
      $display("FAIL cooldown got gnt=%b steps=%0d want 0100 %0d", fire_gnt, m_steps - s_grant, COOLDOWN_STEPS);
    else n_pass++;
  endtask

  task automatic test_hit_vs_step();
    int ex, ey;
    bit ok;
    do_reset();
    set_tank(0, 100, 100, 3); set_tank(1, 200, 200, 1);
    fire_req = 4'b0011;
    tick(); tick();
    fire_req = '0;
    for (int i = 0; i < 10; i++) begin
      if (m_cnt == STEP_CNT - 1) break;
      tick();
    end
    ex = m_x[1]; ey = m_y[1];
    hit_slot = 4'b0010;
    tick();
    hit_slot = '0;
    n_total++;
    if (!slot_expl[1] || slot_act[1] || slot_x[19:10] !== 10'(ex) || slot_y[17:9] !== 9'(ey))
      $display("FAIL hit_step got expl=%b x=%0d y=%0d want 1 %0d %0d", slot_expl[1], slot_x[19:10], slot_y[17:9], ex, ey);
    else n_pass++;
    wait_steps(1, ok);
    n_total++;
    if (!ok || !slot_expl[1]) $display("FAIL expl_hold got expl=%b want 1", slot_expl[1]);
    else n_pass++;
    wait_steps(1, ok);
    n_total++;
    if (!ok || slot_expl[1] || slot_act[1] || slot_x[19:10] !== 10'd0 || slot_y[17:9] !== 9'd0)
      $display("FAIL expl_done got expl=%b x=%0d y=%0d want 0 0 0", slot_expl[1], slot_x[19:10], slot_y[17:9]);
    else n_pass++;
  endtask

  task automatic test_edges();
    int cfg[4][5] = '{'{300, 497, 0, 315, 0}, '{300, 464, 1, 315, 479},
                      '{1009, 200, 2, 0, 215}, '{624, 200, 3, 639, 215}};
    bit ok;
    for (int c = 0; c < 4; c++) begin
      do_reset();
      set_tank(0, cfg[c][0], cfg[c][1], cfg[c][2]);
      fire_req = 4'b0001;
      tick();
      fire_req = '0;
      wait_steps(1, ok);
      n_total++;
      if (!ok || !slot_expl[0] || slot_act[0] || slot_x[9:0] !== 10'(cfg[c][3]) || slot_y[8:0] !== 9'(cfg[c][4]))
        $display("FAIL edge%0d got expl=%b x=%0d y=%0d want 1 %0d %0d", c, slot_expl[0], slot_x[9:0], slot_y[8:0], cfg[c][3], cfg[c][4]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    set_tank(0, 100, 100, 3); set_tank(1, 200, 200, 2); set_tank(2, 300, 300, 1);
    fire_req = 4'b0111;
    tick(); tick(); tick();
    fire_req = '0;
    hit_slot = 4'b0100;
    tick();
    hit_slot = '0;
    n_total++;
    if (slot_act !== 4'b0011 || slot_expl !== 4'b0100) $display("FAIL midflight_setup got %b/%b want 0011/0100", slot_act, slot_expl);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_total++;
    if ({fire_gnt, slot_act, slot_expl, slot_x, slot_y} !== '0)
      $display("FAIL midflight_reset got %h want 0", {fire_gnt, slot_act, slot_expl, slot_x, slot_y});
    else n_pass++;
    fire_req = 4'b1110;
    tick();
    fire_req = '0;
    n_total++;
    if (fire_gnt !== 4'b0010) $display("FAIL midflight_rr got %b want 0010", fire_gnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [24:0] got_v, exp_v;
    logic [3:0] exp_g;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      fire_req = 4'($urandom);
      for (int s = 0; s < N_SLOT; s++) hit_slot[s] = ($urandom_range(15) == 0);
      for (int t = 0; t < N_TANK; t++)
        set_tank(t, int'($urandom_range(624)), int'($urandom_range(464)), int'($urandom_range(3)));
      reset_n = (cyc != 1500);
      tick();
      exp_g = (m_gnt_t < 0) ? 4'b0 : 4'(1 << m_gnt_t);
      n_total++;
      if (fire_gnt !== exp_g) $display("FAIL rand_gnt cyc %0d got %b want %b", cyc, fire_gnt, exp_g);
      else n_pass++;
      for (int s = 0; s < N_SLOT; s++) begin
        got_v = {slot_act[s], slot_expl[s], slot_x[10*s +: 10], slot_y[9*s +: 9], slot_dir[2*s +: 2], slot_owner[2*s +: 2]};
        exp_v = {m_st[s] == 1, m_st[s] == 2, 10'(m_x[s]), 9'(m_y[s]), 2'(m_dir[s]), 2'(m_own[s])};
        n_total++;
        if (got_v !== exp_v) $display("FAIL rand_slot%0d cyc %0d got %h want %h", s, cyc, got_v, exp_v);
        else n_pass++;
      end
    end
    reset_n = 1'b1;
    fire_req = '0;
    hit_slot = '0;
  endtask

  initial begin
    test_reset();
    test_single_fire();
    test_simultaneous();
    test_round_robin();
    test_hit_vs_step();
    test_edges();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
